ext_pipe: RTL
=============

# ext_pipe

Parametrised, registered immediate-extension stage for the pipelined datapath. It accepts a raw immediate, an extension mode and a destination tag under a valid/ready handshake. It computes the extended operand, which may be sign-, zero-, high-placed or branch-scaled, and buffers it in a 2-entry output queue. It sits between decode and execute, where it absorbs one cycle of downstream stall without dropping data and supports a pipeline flush.

## Interface
- IMM_W, 16, immediate width in bits; must be ≥ 1.
- DATA_W, 32, extended operand width; must be ≥ IMM_W + 2.
- TAG_W, 5, width of the sideband tag carried alongside the data, such as the destination register.
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low (asserted when 0); sampled on rising edge of clk.
- in_valid  input  1  upstream presents a request.
- in_ready  output  1  stage can accept; registered, no combinational path from out_ready.
- in_imm  input  IMM_W  raw immediate.
- in_mode  input  3  extension mode (see Operation).
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head.
- out_data  output  DATA_W  extended operand of head entry.
- out_tag  output  TAG_W  tag of head entry.
- out_err  output  1  head entry had an illegal mode.
- flush  input  1  discard all buffered entries and any same-cycle push.

## Operation
- Modes:
  - 3'b000 SIGN: {replicate in_imm[IMM_W-1], in_imm}.
  - 3'b001 ZERO: {zeros, in_imm}.
  - 3'b010 HIGH: in_imm placed in bits [DATA_W-1:DATA_W-IMM_W], lower bits 0.
  - 3'b011 SIGN_SL2: SIGN result shifted left by 2; bits above DATA_W are dropped and the low 2 bits are 0.
- Any other mode: data = 0 and err = 1, and the entry is still queued and delivered.
- Extension is combinational on the input. The result, tag and err are written into the queue on push.
- Queue: 2 entries with head/tail pointers (1 bit each, wrap 1→0) and count 0..2.
- Push = in_valid & in_ready & ~flush.
- Pop = out_valid & out_ready & ~flush.
- in_ready = (count != 2), computed from registered count.
- out_valid = (count != 0).
- out_data, out_tag and out_err always reflect the head entry. They are held stable while out_valid & ~out_ready.
- count update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
  - At count 2, push cannot happen because in_ready is low.
  - At count 0, pop cannot happen.
- flush (priority over push, pop and everything except reset): count←0 and pointers←0. out_valid is low the next cycle. Entry storage contents are don't-care but must not become visible.
- reset (low): count=0, pointers=0, all storage=0. After the edge: out_valid=0, out_data=0, out_tag=0, out_err=0, in_ready=1. Reset mid-transfer discards all entries; no partial state survives.

## Timing
- Latency: request accepted at edge N appears on out_* at cycle N+1 (out_valid high after edge N) if the queue was empty.
- Throughput: 1 per cycle while out_ready stays high (count oscillates 0↔1 or holds at 1).
- A one-cycle out_ready deassertion fills the queue to 2. in_ready drops the following cycle; nothing is lost.
- in_ready reacts to out_ready one cycle late by design: registered ready, so the 2nd entry is the skid slot.
- Upstream must hold in_imm, in_mode and in_tag stable while in_valid & ~in_ready (checked by assertion in bench).

## Structure
- Shared package (ext_pkg): mode constants EXT_SIGN=3'b000, EXT_ZERO=3'b001, EXT_HIGH=3'b010, EXT_SIGN_SL2=3'b011; mode width constant EXT_MODE_W=3.
- One sub-module, ext_core: purely combinational, params IMM_W/DATA_W, ports imm, mode → data, err. The top holds the queue, pointers and handshake.
- Parameter legality checked at elaboration (generate-time error if DATA_W < IMM_W+2).

## Test plan
- Defaults, out_ready=1. Push SIGN 0x8000, ZERO 0x8000, HIGH 0x1234, SIGN_SL2 0xFFFF on consecutive cycles → out_data 0xFFFF8000, 0x00008000, 0x12340000, 0xFFFFFFFC, each one cycle after accept, out_err=0, tags preserved.
- Mode 3'b111, imm 0xABCD, tag 7 → out_data=0, out_err=1, out_tag=7.
- Continuous in_valid with out_ready low for 1 cycle: count reaches 2, in_ready=0 for one cycle. The 4-item stream is delivered in order with no loss or duplication.
- Queue full (2 entries) with flush=1 and in_valid=1 in the same cycle: next cycle out_valid=0, in_ready=1, and the pushed item never appears.
- reset=0 asserted while count=2 and out_ready=0: after the edge all outputs are 0 and in_ready=1. First push after reset release is delivered normally.
- IMM_W=8, DATA_W=16: SIGN 0x80 → 0xFF80; HIGH 0x5A → 0x5A00; SIGN_SL2 0xC0 → 0xFF00.

Source files
------------

// File: rtl/ext_pkg.sv
// ext_pkg: shared constants for the immediate-extension stage.
//   EXT_MODE_W   : width of the extension mode field
//   EXT_SIGN     : sign-extend immediate
//   EXT_ZERO     : zero-extend immediate
//   EXT_HIGH     : immediate placed in the top bits, low bits zero
//   EXT_SIGN_SL2 : sign-extend then scale by 4 (branch offsets)
package ext_pkg;

  localparam int EXT_MODE_W = 3;

  localparam logic [EXT_MODE_W-1:0] EXT_SIGN     = 3'b000;
  localparam logic [EXT_MODE_W-1:0] EXT_ZERO     = 3'b001;
  localparam logic [EXT_MODE_W-1:0] EXT_HIGH     = 3'b010;
  localparam logic [EXT_MODE_W-1:0] EXT_SIGN_SL2 = 3'b011;

endpackage

// File: rtl/ext_core.sv
// ext_core: combinational immediate extender.
// Ports:
//   imm  [IMM_W-1:0]      raw immediate
//   mode [EXT_MODE_W-1:0] extension mode
//   data [DATA_W-1:0]     extended operand (0 for an illegal mode)
//   err                   high for an illegal mode
module ext_core
  import ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic [IMM_W-1:0]      imm,
  input  logic [EXT_MODE_W-1:0] mode,
  output logic [DATA_W-1:0]     data,
  output logic                  err
);

  logic [DATA_W-1:0] w_sext;

  assign w_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (mode)
      EXT_SIGN:     data = w_sext;
      EXT_ZERO:     data = {{(DATA_W-IMM_W){1'b0}}, imm};
      EXT_HIGH:     data = {imm, {(DATA_W-IMM_W){1'b0}}};
      // top two sign bits fall off; DATA_W >= IMM_W+2 keeps imm intact
      EXT_SIGN_SL2: data = {w_sext[DATA_W-3:0], 2'b00};
      default:      err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: registered immediate-extension stage with a 2-entry output queue.
// The second queue entry is the skid slot that absorbs one cycle of
// downstream stall, since in_ready is derived only from the registered count.
// Ports:
//   clk, reset (sync, active-low)
//   in_valid/in_ready/in_imm/in_mode/in_tag : upstream request
//   out_valid/out_ready/out_data/out_tag/out_err : head of queue
//   flush : drops all entries and any same-cycle push
module ext_pipe
  import ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IMM_W-1:0]      in_imm,
  input  logic [EXT_MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_err,
  input  logic                  flush
);

  if (IMM_W < 1) begin : g_bad_imm_w
    $error("ext_pipe: IMM_W must be at least 1");
  end
  if (DATA_W < IMM_W + 2) begin : g_bad_data_w
    $error("ext_pipe: DATA_W must be at least IMM_W + 2");
  end

  logic [DATA_W-1:0] r_data [2];
  logic [TAG_W-1:0]  r_tag  [2];
  logic              r_err  [2];
  logic              r_head;
  logic              r_tail;
  logic [1:0]        r_count;

  logic [DATA_W-1:0] w_ext_data;
  logic              w_ext_err;
  logic              w_push;
  logic              w_pop;

  ext_core #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .data (w_ext_data),
    .err  (w_ext_err)
  );

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_data[r_head];
  assign out_tag   = r_tag[r_head];
  assign out_err   = r_err[r_head];

  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count   <= 2'd0;
      r_head    <= 1'b0;
      r_tail    <= 1'b0;
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_tag[0]  <= '0;
      r_tag[1]  <= '0;
      r_err[0]  <= 1'b0;
      r_err[1]  <= 1'b0;
    end else if (flush) begin
      // storage left as is; count 0 keeps it invisible
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
    end else begin
      if (w_push) begin
        r_data[r_tail] <= w_ext_data;
        r_tag[r_tail]  <= in_tag;
        r_err[r_tail]  <= w_ext_err;
        r_tail         <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
